// File: rtl/leglite_multicycle_ctrl.sv
// Multicycle control FSM for the LEGLite datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// gates the datapath control set per state and times out stalled memory handshakes.
module leglite_multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_inc,
    output logic             pc_branch,
    output logic             reg2loc,
    output logic             branch,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic [2:0]       alu_select,
    output logic             alusrc,
    output logic             regwrite,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);
    localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_ANDI = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              halt_pend_q, halt_pend_d;
    logic              retire;
    logic              in_instr;
    logic [2:0]        op_eff;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            wait_q      <= '0;
            count_q     <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = wait_q;
        count_d     = count_q;
        halt_pend_d = halt_pend_q;
        retire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                halt_pend_d = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready)              state_d = S_DECODE;
                else if (wait_q == WAIT_LAST) state_d = S_ERROR;
                else                         wait_d  = wait_q + WAIT_W'(1);
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_BEQ)                        retire  = 1'b1;
                else if (op_q == OP_LW || op_q == OP_SW)   state_d = S_MEM;
                else                                       state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (op_q == OP_LW) state_d = S_WB;
                    else               retire  = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB:    retire = 1'b1;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        // A halt seen at any point in an instruction is remembered until it retires.
        if (state_q != S_IDLE && state_q != S_ERROR && halt) halt_pend_d = 1'b1;
        if (retire) begin
            count_d     = count_q + CNT_W'(1);
            state_d     = (halt || halt_pend_q) ? S_IDLE : S_FETCH;
            halt_pend_d = 1'b0;
        end
        if (state_d != state_q) wait_d = '0;
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        reg2loc    = 1'b0;
        branch     = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        alu_select = 3'b000;
        alusrc     = 1'b0;
        regwrite   = 1'b0;
        in_instr   = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)    || (state_q == S_WB);
        // In DECODE the freshly loaded IR is the only opcode source; later states use the copy.
        op_eff     = (state_q == S_DECODE) ? opcode : op_q;

        if (in_instr) begin
            case (op_eff)
                OP_SUB, OP_BEQ: alu_select = 3'b001;
                OP_SLT:         alu_select = 3'b010;
                OP_ANDI:        alu_select = 3'b011;
                default:        alu_select = 3'b000;
            endcase
            alusrc  = (op_eff == OP_LW) || (op_eff == OP_SW) ||
                      (op_eff == OP_ADDI) || (op_eff == OP_ANDI);
            reg2loc = (op_eff == OP_ADD) || (op_eff == OP_SUB) || (op_eff == OP_SLT);
        end

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_inc   = imem_ready;
            end
            S_EXEC: begin
                branch    = (op_q == OP_BEQ);
                pc_branch = (op_q == OP_BEQ) && zero;
            end
            S_MEM: begin
                memread  = (op_q == OP_LW);
                memwrite = (op_q == OP_SW);
                memtoreg = (op_q == OP_LW);
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign error       = (state_q == S_ERROR);
    assign instr_count = count_q;

endmodule
